// File: rtl/spi_config_ctrl.sv
// spi_config_ctrl: slave-side configuration sequencer.
// Decodes command bytes F8..FD received over SPI while i_CONFIG is high and
// commits multi-byte payloads atomically from a shadow register. Aborted or
// timed-out sequences never touch the live configuration registers.
module spi_config_ctrl #(
    parameter int                CNT_W          = 14,
    parameter int                TIMEOUT_CYCLES = 4096,
    parameter logic [CNT_W-1:0]  RX_DEFAULT     = 14'h2710,
    parameter logic [CNT_W-1:0]  TX_DEFAULT     = 14'h2500,
    parameter logic [3:0]        OSC_DEFAULT    = 4'h8,
    parameter logic [15:0]       ARTHUR_DEFAULT = 16'h0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_CONFIG,
    input  logic [7:0]       spi_byte,
    input  logic             spi_byte_vld,
    output logic [CNT_W-1:0] ext_count_val_RX,
    output logic [CNT_W-1:0] ext_count_val_TX,
    output logic [3:0]       osc_freq,
    output logic [15:0]      arthur,
    output logic             mode_fc,
    output logic             mode_fd,
    output logic             cfg_busy,
    output logic             cfg_done,
    output logic             cfg_err
);

    // Timeout counter only needs to reach TIMEOUT_CYCLES-1.
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TOUT_MAX_C = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TOUT_ONE_C = {{(TW-1){1'b0}}, 1'b1};

    // Shadow bits above the counter width must be zero for a legal count.
    localparam logic [15:0] HI_MASK_C = 16'(~((32'd1 << CNT_W) - 32'd1));

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_HI = 2'd1,
        ST_WAIT_LO = 2'd2,
        ST_COMMIT  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        TGT_RX     = 2'd0,
        TGT_TX     = 2'd1,
        TGT_OSC    = 2'd2,
        TGT_ARTHUR = 2'd3
    } target_t;

    state_t        state_r;
    target_t       target_r;
    logic [15:0]   shadow_r;
    logic [TW-1:0] tout_r;
    logic          accept_s;
    logic          overflow_s;

    // A byte counts only when both strobe and config window are high.
    assign accept_s   = spi_byte_vld & i_CONFIG;
    assign overflow_s = |(shadow_r & HI_MASK_C);

    // Command sequencer: decode, shadow capture, timeout/abort and commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r          <= ST_IDLE;
            target_r         <= TGT_RX;
            shadow_r         <= 16'h0000;
            tout_r           <= '0;
            ext_count_val_RX <= RX_DEFAULT;
            ext_count_val_TX <= TX_DEFAULT;
            osc_freq         <= OSC_DEFAULT;
            arthur           <= ARTHUR_DEFAULT;
            mode_fc          <= 1'b0;
            mode_fd          <= 1'b0;
            cfg_busy         <= 1'b0;
            cfg_done         <= 1'b0;
            cfg_err          <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    tout_r <= '0;
                    if (accept_s) begin
                        case (spi_byte)
                            8'hF8: begin
                                target_r <= TGT_RX;
                                shadow_r <= 16'h0000;
                                state_r  <= ST_WAIT_HI;
                                cfg_busy <= 1'b1;
                            end
                            8'hF9: begin
                                target_r <= TGT_TX;
                                shadow_r <= 16'h0000;
                                state_r  <= ST_WAIT_HI;
                                cfg_busy <= 1'b1;
                            end
                            8'hFA: begin
                                // Oscillator trim takes a single payload byte.
                                target_r <= TGT_OSC;
                                shadow_r <= 16'h0000;
                                state_r  <= ST_WAIT_LO;
                                cfg_busy <= 1'b1;
                            end
                            8'hFB: begin
                                target_r <= TGT_ARTHUR;
                                shadow_r <= 16'h0000;
                                state_r  <= ST_WAIT_HI;
                                cfg_busy <= 1'b1;
                            end
                            8'hFC: begin
                                mode_fc  <= ~mode_fc;
                                cfg_done <= 1'b1;
                            end
                            8'hFD: begin
                                mode_fd  <= ~mode_fd;
                                cfg_done <= 1'b1;
                            end
                            default: begin
                                cfg_err <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_WAIT_HI, ST_WAIT_LO: begin
                    if (!i_CONFIG) begin
                        // Window closed mid-command: drop it, any strobe is ignored.
                        state_r  <= ST_IDLE;
                        tout_r   <= '0;
                        cfg_busy <= 1'b0;
                        cfg_err  <= 1'b1;
                    end else if (spi_byte_vld) begin
                        // Command codes are plain data here.
                        tout_r <= '0;
                        if (state_r == ST_WAIT_HI) begin
                            shadow_r[15:8] <= spi_byte;
                            state_r        <= ST_WAIT_LO;
                        end else begin
                            shadow_r[7:0] <= spi_byte;
                            state_r       <= ST_COMMIT;
                        end
                    end else if (tout_r == TOUT_MAX_C) begin
                        state_r  <= ST_IDLE;
                        tout_r   <= '0;
                        cfg_busy <= 1'b0;
                        cfg_err  <= 1'b1;
                    end else begin
                        tout_r <= tout_r + TOUT_ONE_C;
                    end
                end
                ST_COMMIT: begin
                    // Commit always completes once entered.
                    case (target_r)
                        TGT_RX: begin
                            if (overflow_s) begin
                                ext_count_val_RX <= {CNT_W{1'b1}};
                                cfg_err          <= 1'b1;
                            end else begin
                                ext_count_val_RX <= shadow_r[CNT_W-1:0];
                            end
                        end
                        TGT_TX: begin
                            if (overflow_s) begin
                                ext_count_val_TX <= {CNT_W{1'b1}};
                                cfg_err          <= 1'b1;
                            end else begin
                                ext_count_val_TX <= shadow_r[CNT_W-1:0];
                            end
                        end
                        TGT_OSC: begin
                            osc_freq <= shadow_r[3:0];
                        end
                        TGT_ARTHUR: begin
                            arthur <= shadow_r;
                        end
                        default: begin
                            arthur <= arthur;
                        end
                    endcase
                    cfg_done <= 1'b1;
                    cfg_busy <= 1'b0;
                    tout_r   <= '0;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    cfg_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_config_ctrl.sv
// tb_spi_config_ctrl: directed self-checking bench for spi_config_ctrl.
module tb_spi_config_ctrl;

    logic        clk;
    logic        rst;
    logic        i_CONFIG;
    logic [7:0]  spi_byte;
    logic        spi_byte_vld;
    logic [13:0] ext_count_val_RX;
    logic [13:0] ext_count_val_TX;
    logic [3:0]  osc_freq;
    logic [15:0] arthur;
    logic        mode_fc;
    logic        mode_fd;
    logic        cfg_busy;
    logic        cfg_done;
    logic        cfg_err;

    int n_checks;
    int n_errors;
    int done_cnt;
    int err_cnt;
    int done_snap;
    int err_snap;
    int first_err;
    int err_pulses;

    spi_config_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .i_CONFIG         (i_CONFIG),
        .spi_byte         (spi_byte),
        .spi_byte_vld     (spi_byte_vld),
        .ext_count_val_RX (ext_count_val_RX),
        .ext_count_val_TX (ext_count_val_TX),
        .osc_freq         (osc_freq),
        .arthur           (arthur),
        .mode_fc          (mode_fc),
        .mode_fd          (mode_fd),
        .cfg_busy         (cfg_busy),
        .cfg_done         (cfg_done),
        .cfg_err          (cfg_err)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count strobe pulses, sampled away from the active edge.
    always @(negedge clk) begin
        if (cfg_done) done_cnt++;
        if (cfg_err) err_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one byte for one cycle; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        spi_byte     = b;
        spi_byte_vld = 1'b1;
        @(negedge clk);
        spi_byte_vld = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    task automatic snap();
        done_snap = done_cnt;
        err_snap  = err_cnt;
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        done_cnt     = 0;
        err_cnt      = 0;
        rst          = 1'b1;
        i_CONFIG     = 1'b0;
        spi_byte     = 8'h00;
        spi_byte_vld = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check_eq("rst_rx",   32'(ext_count_val_RX), 32'h2710);
        check_eq("rst_tx",   32'(ext_count_val_TX), 32'h2500);
        check_eq("rst_osc",  32'(osc_freq), 32'h8);
        check_eq("rst_art",  32'(arthur), 32'h0);
        check_eq("rst_mode", 32'({mode_fc, mode_fd}), 32'h0);
        check_eq("rst_strb", 32'({cfg_busy, cfg_done, cfg_err}), 32'h0);

        // F8 27 10: RX load, done exactly two edges after final strobe
        i_CONFIG = 1'b1;
        snap();
        send_byte(8'hF8);
        send_byte(8'h27);
        send_byte(8'h10);
        check_eq("rx_busy_mid", 32'(cfg_busy), 32'h1);
        check_eq("rx_done_early", 32'(cfg_done), 32'h0);
        @(negedge clk);
        check_eq("rx_done", 32'(cfg_done), 32'h1);
        check_eq("rx_err", 32'(cfg_err), 32'h0);
        check_eq("rx_val", 32'(ext_count_val_RX), 32'h2710);
        settle();
        check_eq("rx_busy_end", 32'(cfg_busy), 32'h0);
        check_eq("rx_done_cnt", 32'(done_cnt - done_snap), 32'd1);

        // F9 / FA / FB commands
        snap();
        send_byte(8'hF9); send_byte(8'h25); send_byte(8'h00); settle();
        send_byte(8'hFA); send_byte(8'hBA); settle();
        send_byte(8'hFB); send_byte(8'h1B); send_byte(8'hAE); settle();
        check_eq("tx_val", 32'(ext_count_val_TX), 32'h2500);
        check_eq("osc_val", 32'(osc_freq), 32'hA);
        check_eq("art_val", 32'(arthur), 32'h1BAE);
        check_eq("multi_done", 32'(done_cnt - done_snap), 32'd3);
        check_eq("multi_err", 32'(err_cnt - err_snap), 32'd0);

        // F8 FF FF: overflow saturates with err alongside done
        send_byte(8'hF8); send_byte(8'hFF); send_byte(8'hFF);
        @(negedge clk);
        check_eq("ovf_done", 32'(cfg_done), 32'h1);
        check_eq("ovf_err", 32'(cfg_err), 32'h1);
        check_eq("ovf_rx", 32'(ext_count_val_RX), 32'h3FFF);
        settle();

        // F9 12 then window closes with a simultaneous strobe
        snap();
        send_byte(8'hF9); send_byte(8'h12);
        @(negedge clk);
        i_CONFIG     = 1'b0;
        spi_byte     = 8'h34;
        spi_byte_vld = 1'b1;
        @(negedge clk);
        spi_byte_vld = 1'b0;
        check_eq("abort_err", 32'(cfg_err), 32'h1);
        check_eq("abort_busy", 32'(cfg_busy), 32'h0);
        send_byte(8'h56);
        settle();
        check_eq("abort_tx", 32'(ext_count_val_TX), 32'h2500);
        check_eq("abort_errcnt", 32'(err_cnt - err_snap), 32'd1);
        check_eq("abort_donecnt", 32'(done_cnt - done_snap), 32'd0);
        i_CONFIG = 1'b1;

        // FB 01 then silence: timeout after 4096 edges
        send_byte(8'hFB); send_byte(8'h01);
        check_eq("to_busy", 32'(cfg_busy), 32'h1);
        first_err  = -1;
        err_pulses = 0;
        for (int n = 1; n <= 4100; n++) begin
            @(negedge clk);
            if (cfg_err) begin
                err_pulses++;
                if (first_err < 0) first_err = n;
            end
        end
        check_eq("to_first", 32'(first_err), 32'd4096);
        check_eq("to_pulses", 32'(err_pulses), 32'd1);
        check_eq("to_art", 32'(arthur), 32'h1BAE);
        check_eq("to_busy_end", 32'(cfg_busy), 32'h0);

        // FC FD FC mode toggles, then illegal byte
        snap();
        send_byte(8'hFC); send_byte(8'hFD); send_byte(8'hFC); settle();
        check_eq("mode_fc", 32'(mode_fc), 32'h0);
        check_eq("mode_fd", 32'(mode_fd), 32'h1);
        check_eq("mode_done", 32'(done_cnt - done_snap), 32'd3);
        snap();
        send_byte(8'h42); settle();
        check_eq("ill_err", 32'(err_cnt - err_snap), 32'd1);
        check_eq("ill_done", 32'(done_cnt - done_snap), 32'd0);

        // Reset during WAIT_LO of FA
        send_byte(8'hFA);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("mrst_osc", 32'(osc_freq), 32'h8);
        check_eq("mrst_rx", 32'(ext_count_val_RX), 32'h2710);
        check_eq("mrst_art", 32'(arthur), 32'h0);
        check_eq("mrst_mode", 32'({mode_fc, mode_fd}), 32'h0);
        check_eq("mrst_strb", 32'({cfg_busy, cfg_done, cfg_err}), 32'h0);
        // A byte now must be decoded as a command (IDLE), not as payload
        send_byte(8'h05);
        check_eq("mrst_idle_err", 32'(cfg_err), 32'h1);
        check_eq("mrst_idle_done", 32'(cfg_done), 32'h0);
        settle();
        check_eq("mrst_osc_end", 32'(osc_freq), 32'h8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
